// File: rtl/panel_input_reader_pkg.sv
// Shared definitions for the panel input path and the display register bank.
// Holds the write-side FSM state encoding, the register bank geometry and
// the default debounce length (10 ms at 50 MHz).
package panel_input_reader_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WRITE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 4;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Pointer step; REG_COUNT is a power of two so the add wraps 7 -> 0.
  function automatic logic [REG_ADDR_W-1:0] next_addr(input logic [REG_ADDR_W-1:0] a);
    return a + REG_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/panel_input_reader_if.sv
// Register-bank write bus driven by the panel input reader.
//   wr_en   : one-cycle write strobe
//   wr_addr : register index, valid while wr_en=1
//   wr_data : write value, valid while wr_en=1
//   state   : write FSM state, exported for observation
// Handshake: wr_en is a fire-and-forget strobe with no ready/back-pressure;
// the bank must accept the write on the single cycle wr_en is high.
// wr_addr/wr_data hold their last values while wr_en is low.
interface panel_input_reader_if;
  import panel_input_reader_pkg::*;

  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [REG_DATA_W-1:0] wr_data;
  state_e                state;

  modport master (output wr_en, output wr_addr, output wr_data, output state);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  state);
endinterface

// File: rtl/panel_input_reader_key_debouncer.sv
// Pushbutton synchroniser and debouncer.
//   clock       : system clock
//   reset       : synchronous, active-high
//   key_n       : raw active-low pushbutton, asynchronous to clock
//   key_pressed : debounced level, 1 = held
// A level change is accepted only after DEBOUNCE_CYCLES consecutive edges
// on which the synchronised key differs from the stable level.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      if (sync2_q != stable_q) begin
        // This edge is the DEBOUNCE_CYCLES-th differing one when the
        // counter already holds DEBOUNCE_CYCLES-1.
        if (cnt_q == CNT_LAST) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign key_pressed = ~stable_q;

endmodule

// File: rtl/panel_input_reader.sv
// Panel input reader: turns switches plus one pushbutton into single-cycle
// register-write transactions for the 8 x 4-bit display register bank.
//   clock, reset : system clock, synchronous active-high reset
//   key_n        : raw active-low pushbutton
//   sw_data      : value to write
//   sw_addr      : target register when auto_inc=0
//   auto_inc     : 1 = write at internal pointer and post-increment it
//   wr           : write bus (wr_en / wr_addr / wr_data / state)
//   cur_addr     : current internal pointer
//   key_pressed  : debounced key level
module panel_input_reader
  import panel_input_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_n,
  input  logic [REG_DATA_W-1:0] sw_data,
  input  logic [REG_ADDR_W-1:0] sw_addr,
  input  logic                  auto_inc,
  panel_input_reader_if.master  wr,
  output logic [REG_ADDR_W-1:0] cur_addr,
  output logic                  key_pressed
);

  state_e                state_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [REG_DATA_W-1:0] wr_data_q;
  logic [REG_ADDR_W-1:0] ptr_q;
  logic                  inc_q;
  logic                  key_pressed_w;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clock       (clock),
    .reset       (reset),
    .key_n       (key_n),
    .key_pressed (key_pressed_w)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
      inc_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // In manual mode the pointer follows the switches so cur_addr
          // shows where the next write will land.
          if (!auto_inc) begin
            ptr_q <= sw_addr;
          end
          if (key_pressed_w) begin
            state_q   <= WRITE;
            wr_data_q <= sw_data;
            wr_addr_q <= auto_inc ? ptr_q : sw_addr;
            inc_q     <= auto_inc;
          end
        end
        WRITE: begin
          state_q <= WAIT_RELEASE;
          if (inc_q) begin
            ptr_q <= next_addr(ptr_q);
          end
        end
        WAIT_RELEASE: begin
          if (!key_pressed_w) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr.wr_en     = (state_q == WRITE);
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_data   = wr_data_q;
  assign wr.state     = state_q;
  assign cur_addr     = ptr_q;
  assign key_pressed  = key_pressed_w;

endmodule

// File: doc/panel_input_reader.md
Name: panel_input_reader

Overview:
- Input-side counterpart of the eight-digit hex display path: it turns board switches and one pushbutton into register-write transactions for the 8 x 4-bit register bank that drives the displays.
- The pushbutton is synchronised and debounced; each confirmed press issues exactly one single-cycle write strobe with the selected address and data.
- Optional auto-increment mode steps the write address 0..7 with wrap, so the whole bank can be loaded from switches.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw pushbutton, active-low, asynchronous to clock.
- sw_data  in  4  value to write.
- sw_addr  in  3  target register index when auto_inc=0.
- auto_inc  in  1  1 = use internal pointer and post-increment it.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  3  register index, valid while wr_en=1.
- wr_data  out  4  write value, valid while wr_en=1.
- cur_addr  out  3  current internal pointer, for display or LEDs.
- key_pressed  out  1  debounced key level, 1 = held.

Behaviour:
- Reset, synchronous and active-high:
  - sync flops = 1; debounced level = released; counter = 0.
  - FSM = IDLE; pointer = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0, cur_addr = 0, key_pressed = 0.
- Synchroniser: two flops on key_n, with no logic between them.
- Debouncer:
  - Each edge where the sync output differs from the stable level, the counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, the stable level flips and the counter clears.
  - Any edge where the sync output equals the stable level clears the counter, so glitches shorter than DEBOUNCE_CYCLES are ignored.
  - key_pressed = NOT stable level.
- FSM states: IDLE, WRITE, WAIT_RELEASE.
  - IDLE -> WRITE when key_pressed=1. On that edge, latch:
    - wr_data <= sw_data.
    - wr_addr <= (auto_inc ? pointer : sw_addr).
    - the auto_inc value itself.
  - WRITE: wr_en=1 for exactly this one cycle, decoded from state. Always -> WAIT_RELEASE. If the latched auto_inc=1, pointer <= pointer+1 mod 8 (7 -> 0).
  - WAIT_RELEASE -> IDLE when key_pressed=0. Holding the key never repeats a write.
- Pointer:
  - While auto_inc=0 and FSM is IDLE, pointer <= sw_addr each cycle.
  - While auto_inc=1, the pointer changes only in WRITE.
  - cur_addr = pointer.
- Latency: let e0 be the first edge sampling key_n=0, with key_n held low.
  - Stable level flips at e(DEBOUNCE_CYCLES+1).
  - FSM enters WRITE at e(DEBOUNCE_CYCLES+2).
  - wr_en is high from e(DEBOUNCE_CYCLES+2) to e(DEBOUNCE_CYCLES+3).
- Switch changes after the latch edge do not affect the in-flight write.
- wr_addr and wr_data hold their last values outside WRITE.
- Reset mid-operation: an immediate return to the reset state with no strobe. A key still held after reset is debounced afresh and counts as a new press.
- Release bounce during WAIT_RELEASE is absorbed by the debouncer and produces no extra write.

Decomposition:
- Shared package holds:
  - the FSM state typedef (IDLE=2'd0, WRITE=2'd1, WAIT_RELEASE=2'd2);
  - REG_COUNT=8, REG_ADDR_W=3, REG_DATA_W=4, shared with the display path;
  - the DEBOUNCE_CYCLES default.
- One sub-module, key_debouncer: synchroniser, counter and stable level. Inputs clock, reset, key_n; output key_pressed. Parameterised with DEBOUNCE_CYCLES and CNT_W.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: assert reset 2 cycles with key_n=0 -> all outputs 0 during and right after reset; first wr_en appears after a fresh debounce of 7 edges, not earlier.
- Single write: auto_inc=0, sw_addr=5, sw_data=4'hA, key_n low from e0 and held 20 cycles -> wr_en high only between e6 and e7, wr_addr=5, wr_data=A; no further strobe while held.
- Glitch reject: key_n low for 3 cycles, then high -> no wr_en, key_pressed stays 0. Bouncy press (low 2, high 1, low held) -> exactly one wr_en.
- Auto-increment wrap: auto_inc=1 after reset, data 1..9 over 9 clean presses -> wr_addr sequence 0,1,...,7,0; cur_addr=1 at end.
- Data latch: sw_data changes from 3 to C on the cycle after the latch edge -> written value is 3.
- Reset mid-press: reset pulsed while FSM is in WAIT_RELEASE with key held -> no wr_en during reset, FSM returns to IDLE, and one new write follows after debounce.
